// File: rtl/uart_tx_serial_pkg.sv
// uart_tx_serial_pkg: constants shared along the UART path.
// FSM state encodings, ASCII codes and the bit-period helper.
package uart_tx_serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [7:0] ASCII_CR = 8'd13;
  localparam logic [7:0] ASCII_LF = 8'd10;
  localparam logic [7:0] ASCII_SP = 8'd32;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter producing one tick per bit.
// Shared by the UART transmitter and receiver.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serial.sv
// uart_tx_serial: 8N1 UART transmitter, LSB first.
// Accepts a byte on tstart && tready and drives a registered txd.
module uart_tx_serial
  import uart_tx_serial_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tstart,
  input  logic [7:0] tbus,
  output logic       tready,
  output logic       txd
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_serial: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serial: STOP_BITS must be 1 or 2");
  end

  logic [1:0] state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       tick;
  logic       accept;
  logic       busy;

  assign accept = tready && tstart;
  assign busy   = (state != ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (busy),
    .tick(tick)
  );

  // bit_idx counts data bits in DATA and stop bits in STOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      txd     <= 1'b1;
      tready  <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            shift   <= tbus;
            tready  <= 1'b0;
            txd     <= 1'b0;
            bit_idx <= '0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            txd     <= shift[0];
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              txd     <= 1'b1;
              bit_idx <= '0;
              state   <= ST_STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              tready  <= 1'b1;
              bit_idx <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serial.sv
// tb_uart_tx_serial: scoreboard bench for uart_tx_serial.
// Two instances: 1 stop bit and 2 stop bits, 10 clks per bit.
module tb_uart_tx_serial;
  import uart_tx_serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tstart, tstart2;
  logic [7:0] tbus, tbus2;
  logic       tready, tready2;
  logic       txd, txd2;

  int errors = 0;
  int checks = 0;
  int frames0 = 0;
  int frames1 = 0;
  bit rst_hit0, rst_hit1;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  uart_tx_serial #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .STOP_BITS(1)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .tstart(tstart),
    .tbus  (tbus),
    .tready(tready),
    .txd   (txd)
  );

  uart_tx_serial #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .STOP_BITS(2)
  ) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .tstart(tstart2),
    .tbus  (tbus2),
    .tready(tready2),
    .txd   (txd2)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int d);
    return d ? txd2 : txd;
  endfunction

  function automatic logic rdy(input int d);
    return d ? tready2 : tready;
  endfunction

  always @(posedge rst) begin
    rst_hit0 = 1'b1;
    rst_hit1 = 1'b1;
  end

  task automatic monitor(input int d);
    logic [7:0] b;
    logic       st;
    logic [7:0] exp;
    int         nsb;
    logic       sp;
    bit         hit;
    nsb = d ? 2 : 1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || line(d) !== 1'b0) continue;
      if (d != 0) rst_hit1 = 1'b0;
      else rst_hit0 = 1'b0;
      repeat (5) @(negedge clk);
      st = line(d);
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        b[i] = line(d);
      end
      sp = 1'b1;
      for (int s = 0; s < nsb; s++) begin
        repeat (10) @(negedge clk);
        sp = sp & line(d);
      end
      hit = (d != 0) ? rst_hit1 : rst_hit0;
      if (hit) continue;
      check($sformatf("mon%0d_start", d), st, 1'b0);
      check($sformatf("mon%0d_stop", d), sp, 1'b1);
      if (d != 0) begin
        frames1++;
        check("mon1_pending", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          exp = q1.pop_front();
          check("mon1_byte", b, exp);
        end
      end else begin
        frames0++;
        check("mon0_pending", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          exp = q0.pop_front();
          check("mon0_byte", b, exp);
        end
      end
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk);
    if (d != 0) begin
      tstart2 = 1'b1;
      tbus2   = b;
      q1.push_back(b);
    end else begin
      tstart = 1'b1;
      tbus   = b;
      q0.push_back(b);
    end
    @(negedge clk);
    if (d != 0) begin
      tstart2 = 1'b0;
      tbus2   = ~b;
    end else begin
      tstart = 1'b0;
      tbus   = ~b;
    end
  endtask

  task automatic wait_ready(
    input  int d,
    output int n,
    output int hi
  );
    n  = 0;
    hi = 0;
    while (rdy(d) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (line(d) === 1'b1 && rdy(d) !== 1'b1) hi++;
    end
    if (n >= 400) check("ready_timeout", rdy(d), 1'b1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    int n, hi;
    logic [7:0] dropped;
    rst     = 1'b0;
    tstart  = 1'b0;
    tstart2 = 1'b0;
    tbus    = '0;
    tbus2   = '0;

    // reset, asynchronous assert and clean release
    #2 rst = 1'b1;
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_tready", tready, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_txd", txd, 1'b1);
    check("rel_tready", tready, 1'b1);
    check("rel_txd2", txd2, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("idle_rst_txd", txd, 1'b1);
    check("idle_rst_tready", tready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rel_tready", tready, 1'b1);

    // single byte 'A'
    send(0, 8'h41);
    check("a_tready_low", tready, 1'b0);
    check("a_txd_start", txd, 1'b0);
    wait_ready(0, n, hi);
    check("a_frame_len", n, 100);
    repeat (5) @(negedge clk);

    // back-to-back CR, LF with tstart held
    @(negedge clk);
    tstart = 1'b1;
    tbus   = ASCII_CR;
    q0.push_back(ASCII_CR);
    @(negedge clk);
    tbus = ASCII_LF;
    q0.push_back(ASCII_LF);
    check("b2b_busy", tready, 1'b0);
    wait_ready(0, n, hi);
    check("b2b_len1", n, 100);
    check("b2b_idle_txd", txd, 1'b1);
    @(negedge clk);
    tstart = 1'b0;
    check("b2b_restart_txd", txd, 1'b0);
    check("b2b_restart_tready", tready, 1'b0);
    wait_ready(0, n, hi);
    check("b2b_len2", n, 100);
    repeat (5) @(negedge clk);

    // request while busy is ignored
    send(0, 8'h55);
    repeat (30) @(negedge clk);
    tstart = 1'b1;
    tbus   = 8'hFF;
    repeat (2) @(negedge clk);
    tstart = 1'b0;
    wait_ready(0, n, hi);
    check("ign_len", n + 32, 100);
    repeat (150) @(negedge clk);
    check("ign_frames", frames0, 4);
    check("ign_txd_idle", txd, 1'b1);

    // reset during data bit 3
    send(0, 8'hF0);
    repeat (45) @(negedge clk);
    check("mid_bit3_txd", txd, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_tready", tready, 1'b1);
    dropped = q0.pop_front();
    check("mid_dropped", dropped, 8'hF0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    check("mid_no_resend", frames0, 4);
    send(0, ASCII_SP);
    wait_ready(0, n, hi);
    check("sp_len", n, 100);

    // two stop bits
    send(1, 8'h00);
    wait_ready(1, n, hi);
    check("sb2_len", n, 110);
    check("sb2_stop_high", hi, 20);

    repeat (20) @(negedge clk);
    check("end_frames0", frames0, 5);
    check("end_frames1", frames1, 1);
    check("end_q0_empty", q0.size(), 0);
    check("end_q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
